nonce_report_tx: RTL and testbench



---
 rtl/nonce_report_tx_pkg.sv | 17 +
 rtl/nonce_report_tx_fifo.sv | 58 +++++
 rtl/nonce_report_tx.sv | 112 +++++++++++
 tb/tb_nonce_report_tx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/nonce_report_tx_pkg.sv
// Shared definitions for the golden-nonce byte-stream transmitter.
// Frame layout: sync byte, then nonce bytes 3..0 (MSB first).
package nonce_report_tx_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         FRAME_BYTES       = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_B3   = 3'd2,
    ST_B2   = 3'd3,
    ST_B1   = 3'd4,
    ST_B0   = 3'd5
  } tx_state_e;

endpackage

// File: rtl/nonce_report_tx_fifo.sv
// Single-clock DEPTH x 32 FIFO with first-word fall-through read data.
// A write to a full FIFO is accepted when a read happens on the same edge.
module nonce_fifo #(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  output logic [31:0]   rd_data,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_rd;
  logic          do_wr;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign level   = count;
  assign rd_data = mem[rd_ptr];

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // NOTE: storage has no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nonce_report_tx.sv
// Golden-nonce reporter: buffers nonces and serializes each as a 5-byte
// frame (sync + 4 nonce bytes, MSB first) over a valid/ready byte link.
module nonce_report_tx
  import nonce_report_tx_pkg::*;
#(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_new_nonce,
  input  logic [31:0]             rx_golden_nonce,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    rx_ready,
  output logic [$clog2(DEPTH):0]  tx_level,
  output logic                    tx_overflow,
  output logic [7:0]              tx_dropped
);

  tx_state_e   state_q;
  tx_state_e   state_d;
  logic [31:0] shift_q;
  logic [31:0] fifo_rd_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        shift_en;
  logic        drop;

  nonce_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rx_new_nonce),
    .wr_data (rx_golden_nonce),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .level   (tx_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    shift_en = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (rx_ready) state_d = ST_B3;
      end
      ST_B3, ST_B2, ST_B1: begin
        tx_valid = 1'b1;
        tx_data  = shift_q[31:24];
        if (rx_ready) begin
          shift_en = 1'b1;
          state_d  = (state_q == ST_B3) ? ST_B2 :
                     (state_q == ST_B2) ? ST_B1 : ST_B0;
        end
      end
      ST_B0: begin
        tx_valid = 1'b1;
        tx_data  = shift_q[31:24];
        if (rx_ready) begin
          // Chain straight into the next frame when one is already waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_SYNC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop)           shift_q <= fifo_rd_data;
      else if (shift_en) shift_q <= {shift_q[23:0], 8'h00};
    end
  end

  // A same-edge pop frees a slot, so only a full FIFO without a pop drops.
  assign drop = rx_new_nonce && fifo_full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_overflow <= 1'b0;
      tx_dropped  <= 8'h00;
    end else if (drop) begin
      tx_overflow <= 1'b1;
      if (tx_dropped != 8'hFF) tx_dropped <= tx_dropped + 8'd1;
    end
  end

endmodule

// File: tb/tb_nonce_report_tx.sv
// Scoreboard bench for nonce_report_tx: a transaction-level model predicts
// the byte stream and counters; a negedge monitor compares DUT output.
module tb_nonce_report_tx;
  import nonce_report_tx_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_new_nonce = 1'b0;
  logic [31:0] rx_golden_nonce = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        rx_ready = 1'b0;
  logic [3:0]  tx_level;
  logic        tx_overflow;
  logic [7:0]  tx_dropped;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nonce_report_tx #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_new_nonce    (rx_new_nonce),
    .rx_golden_nonce (rx_golden_nonce),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .rx_ready        (rx_ready),
    .tx_level        (tx_level),
    .tx_overflow     (tx_overflow),
    .tx_dropped      (tx_dropped)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: waiting nonces, bytes left in the frame on the wire,
  // and the expected byte stream that the monitor consumes.
  logic [31:0] m_q[$];
  logic [7:0]  exp_q[$];
  int          m_left = 0;
  int          m_drop = 0;
  bit          m_ovf  = 1'b0;
  bit          m_active, m_xfer, m_pop;
  int          m_before;
  logic [31:0] m_w;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      exp_q.delete();
      m_left = 0;
      m_drop = 0;
      m_ovf  = 1'b0;
    end else begin
      m_active = (m_left > 0);
      m_xfer   = m_active && rx_ready;
      m_before = m_q.size();
      m_pop    = (m_before > 0) && (!m_active || (m_xfer && m_left == 1));
      if (m_xfer) m_left--;
      if (m_pop) begin
        m_w = m_q.pop_front();
        exp_q.push_back(8'hA5);
        exp_q.push_back(m_w[31:24]);
        exp_q.push_back(m_w[23:16]);
        exp_q.push_back(m_w[15:8]);
        exp_q.push_back(m_w[7:0]);
        m_left = FRAME_BYTES;
      end
      if (rx_new_nonce) begin
        if (m_before < DEPTH || m_pop) m_q.push_back(rx_golden_nonce);
        else begin
          m_ovf  = 1'b1;
          m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end
      end
    end
  end

  // Monitor: every cycle, compare status and the current byte (also while stalled).
  always @(negedge clk) begin
    if (!reset) begin
      check("valid", 32'(tx_valid), 32'(m_left > 0));
      check("level", 32'(tx_level), 32'(m_q.size()));
      check("dropped", 32'(tx_dropped), 32'(m_drop));
      check("overflow", 32'(tx_overflow), 32'(m_ovf));
      if (tx_valid) begin
        check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check("data", 32'(tx_data), 32'(exp_q[0]));
          if (rx_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cycle(input logic nn, input logic [31:0] v, input logic rdy);
    rx_new_nonce    = nn;
    rx_golden_nonce = v;
    rx_ready        = rdy;
    @(posedge clk);
    #1;
    rx_new_nonce = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_valid", 32'(tx_valid), 32'd0);
    check("reset_level", 32'(tx_level), 32'd0);
    check("reset_data", 32'(tx_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_dropped", 32'(tx_dropped), 32'd0);
    check("reset_overflow", 32'(tx_overflow), 32'd0);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((m_q.size() > 0 || m_left > 0 || exp_q.size() > 0) && k < 400) begin
      cycle(1'b0, 32'h0, 1'b1);
      k++;
    end
    check(name, 32'(k < 400), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single nonce
    cycle(1'b1, 32'h8000_1234, 1'b1);
    repeat (8) cycle(1'b0, 32'h0, 1'b1);
    check("single_idle_valid", 32'(tx_valid), 32'd0);
    check("single_idle_level", 32'(tx_level), 32'd0);

    // Backpressure with ready pattern 1,0,0,1,...
    cycle(1'b1, 32'h0102_0304, 1'b1);
    for (int i = 0; i < 24; i++) cycle(1'b0, 32'h0, (i % 3) == 2);
    drain("backpressure_drain");

    // Back-to-back strobes
    cycle(1'b1, 32'h1111_1111, 1'b1);
    cycle(1'b1, 32'h2222_2222, 1'b1);
    drain("b2b_drain");

    // Overflow: 10 strobes while stalled
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'(i), 1'b0);
    check("ovf_level", 32'(tx_level), 32'd8);
    check("ovf_dropped", 32'(tx_dropped), 32'd1);
    check("ovf_flag", 32'(tx_overflow), 32'd1);
    drain("ovf_drain");
    check("ovf_sticky", 32'(tx_overflow), 32'd1);

    // Full FIFO with a strobe on the B0 transfer edge
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1'b1, 32'h5000_0000 + 32'(i), 1'b0);
    repeat (4) cycle(1'b0, 32'h0, 1'b1);
    check("full_pre_level", 32'(tx_level), 32'd8);
    cycle(1'b1, 32'hCAFE_0001, 1'b1);
    check("full_pop_level", 32'(tx_level), 32'd8);
    check("full_pop_dropped", 32'(tx_dropped), 32'd0);
    drain("full_pop_drain");

    // Reset mid-frame (during B2), with another nonce queued
    cycle(1'b1, 32'h7777_8888, 1'b1);
    cycle(1'b1, 32'h9999_AAAA, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    do_reset();
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1);
    repeat (10) cycle(1'b0, 32'h0, 1'b1);
    check("post_reset_idle", 32'(tx_valid), 32'd0);

    // Drop counter saturation
    for (int i = 0; i < 300; i++) cycle(1'b1, $urandom, 1'b0);
    check("sat_dropped", 32'(tx_dropped), 32'd255);
    check("sat_level", 32'(tx_level), 32'd8);
    drain("sat_drain");
    check("sat_hold", 32'(tx_dropped), 32'd255);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 200; i++)
      cycle($urandom_range(0, 1) == 0, $urandom, $urandom_range(0, 4) == 0);
    drain("random_drain");
    check("random_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
